// File: rtl/uart_cmd_parser.sv
// Purpose: assembles framed host commands (AA, CMD, LEN, payload, CHK) from the UART byte stream.
// Latency: cmd_valid/frame_err rise on the clock edge that accepts the closing byte (or on timeout expiry).
// Backpressure: none; a byte is consumed in every rx_valid cycle, and back-to-back frames are accepted.
//
// Ports:
//   clk_50M    in   system clock
//   rst        in   asynchronous active-high reset
//   rx_valid   in   one-cycle strobe qualifying rx_byte
//   rx_byte    in   received byte
//   cmd_valid  out  one-cycle pulse, good frame decoded
//   cmd_code   out  CMD byte of the last good frame
//   cmd_arg    out  payload of the last good frame, big-endian, right-aligned, zero-extended
//   cmd_len    out  payload length of the last good frame
//   frame_err  out  one-cycle pulse, frame aborted
//   err_code   out  abort reason (1 bad LEN, 2 checksum, 3 timeout), held until the next abort
//   busy       out  high while a frame is being assembled
//   frame_cnt  out  good frame counter, wraps at 16 bits
module uart_cmd_parser #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         MAX_LEN        = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         TO_W           = 16
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_arg,
    output logic [2:0]  cmd_len,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4
    } state_t;

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Frame assembly state
    state_t          state_q;
    logic [7:0]      chk_q;        // running XOR of CMD, LEN and payload
    logic [31:0]     shift_q;      // payload shift register, newest byte in [7:0]
    logic [2:0]      pay_cnt_q;    // payload bytes received so far
    logic [2:0]      len_q;        // LEN of the frame in progress
    logic [7:0]      code_pend_q;  // CMD of the frame in progress
    logic [TO_W-1:0] to_q;         // idle cycles since the last accepted byte

    // Registered outputs
    logic        cmd_valid_q;
    logic [7:0]  cmd_code_q;
    logic [31:0] cmd_arg_q;
    logic [2:0]  cmd_len_q;
    logic        frame_err_q;
    logic [1:0]  err_code_q;
    logic        busy_q;
    logic [15:0] frame_cnt_q;

    logic [7:0] byte_chk;
    logic [2:0] pay_cnt_inc;
    logic       timeout_hit;

    always_comb begin
        byte_chk    = chk_q ^ rx_byte;
        pay_cnt_inc = pay_cnt_q + 3'd1;
        // A byte arriving on the expiry cycle takes precedence over the timeout.
        timeout_hit = (state_q != S_IDLE) && !rx_valid && (to_q == TO_LAST);
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            chk_q       <= '0;
            shift_q     <= '0;
            pay_cnt_q   <= '0;
            len_q       <= '0;
            code_pend_q <= '0;
            to_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_arg_q   <= '0;
            cmd_len_q   <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Pulses default low; they are raised for one cycle below.
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // Inter-byte watchdog: only runs while a frame is open.
            if ((state_q == S_IDLE) || rx_valid || timeout_hit) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end

            if (timeout_hit) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
            end else if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        // Non-header bytes between frames are line noise; drop them quietly.
                        if (rx_byte == HEADER) begin
                            chk_q     <= '0;
                            shift_q   <= '0;
                            pay_cnt_q <= '0;
                            state_q   <= S_CMD;
                            busy_q    <= 1'b1;
                        end
                    end

                    S_CMD: begin
                        code_pend_q <= rx_byte;
                        chk_q       <= byte_chk;
                        state_q     <= S_LEN;
                    end

                    S_LEN: begin
                        if (rx_byte > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            // Upper bits are known zero here since LEN <= MAX_LEN.
                            len_q   <= rx_byte[2:0];
                            chk_q   <= byte_chk;
                            state_q <= (rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                    end

                    S_PAYLOAD: begin
                        // A header value here is ordinary data; no mid-frame resync.
                        shift_q   <= {shift_q[23:0], rx_byte};
                        chk_q     <= byte_chk;
                        pay_cnt_q <= pay_cnt_inc;
                        if (pay_cnt_inc == len_q) begin
                            state_q <= S_CHK;
                        end
                    end

                    S_CHK: begin
                        if (rx_byte == chk_q) begin
                            cmd_valid_q <= 1'b1;
                            cmd_code_q  <= code_pend_q;
                            cmd_arg_q   <= shift_q;
                            cmd_len_q   <= len_q;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            // Decoded outputs keep the last good frame.
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign cmd_len   = cmd_len_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (one-cycle byte-valid strobe plus 8-bit byte) and assembles framed host commands.
- Validates each frame's length and checksum, then presents a decoded command code plus a 32-bit argument to the ultrasound control logic.
- Bad frames and stalled frames are reported as one-cycle error pulses with a reason code.
- Frame format: 0xAA header, CMD byte, LEN byte (0..4), LEN payload bytes, CHK byte. CHK = XOR of CMD, LEN and all payload bytes.

Parameters:
- HEADER, 8'hAA: start-of-frame byte.
- MAX_LEN, 4: maximum payload bytes. The fixed 32-bit argument bounds this at 4.
- TIMEOUT_CYCLES, 50000: idle clock cycles allowed between bytes inside a frame (about 11 byte-times at 115200 baud, 50 MHz).
- TO_W, 16: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_byte is valid this cycle.
- rx_byte  input  8  received byte.
- cmd_valid  output  1  one-cycle pulse: a good frame was decoded.
- cmd_code  output  8  CMD byte of the last good frame.
- cmd_arg  output  32  payload, big-endian, right-aligned, zero-extended.
- cmd_len  output  3  payload length of the last good frame.
- frame_err  output  1  one-cycle pulse: frame aborted.
- err_code  output  2  abort reason: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout. Held until the next error.
- busy  output  1  high whenever state != IDLE.
- frame_cnt  output  16  count of good frames. Wraps from 0xFFFF to 0.

Behaviour:
- Interface decision: one clock (clk_50M); reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal registers (checksum, argument shift register, payload counter, timeout counter) cleared. Reset mid-frame discards the partial frame and produces no error pulse.
- All outputs are registered. cmd_valid / frame_err rise on the clock edge that accepts the triggering byte (or that the timeout expires). They are high for exactly one cycle.
- Bytes are processed only in cycles where rx_valid = 1. Other cycles only advance the timeout counter.
- State IDLE:
  - rx_byte == HEADER: clear checksum, shift register and payload count; go to CMD.
  - Any other byte: silently ignored, no error.
- State CMD: store the byte as the pending code; checksum ^= byte; go to LEN.
- State LEN:
  - byte > MAX_LEN: frame_err with err_code = 1; go to IDLE.
  - byte == 0: store LEN, checksum ^= byte, go to CHK.
  - Otherwise: store LEN, checksum ^= byte, go to PAYLOAD.
- State PAYLOAD:
  - Per byte: shift <= {shift[23:0], byte}; checksum ^= byte; payload count + 1.
  - When the count reaches LEN, go to CHK.
- State CHK:
  - byte == checksum: load cmd_code, cmd_arg (from the shift register) and cmd_len; pulse cmd_valid; frame_cnt + 1.
  - Otherwise: frame_err with err_code = 2.
  - Either way, go to IDLE.
- On any error, cmd_code, cmd_arg and cmd_len keep their previous values.
- A HEADER byte received inside a frame is treated as data; the parser does not resynchronise mid-frame.
- Timeout:
  - The counter clears on every accepted byte and while in IDLE.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES-1 outside IDLE: frame_err with err_code = 3; go to IDLE.
  - If rx_valid arrives in the same cycle as expiry, the byte wins: it is processed and the counter clears.
- An error and cmd_valid can never pulse in the same cycle.
- The block accepts back-to-back frames. A HEADER byte may arrive on the cycle immediately after the CHK byte.

Test Plan:
- Good frame: bytes AA 03 02 12 34 27 -> one cmd_valid pulse; cmd_code = 03, cmd_arg = 0x00001234, cmd_len = 2, frame_cnt = 1, busy low afterwards.
- Zero-length frame after garbage: 55 00 AA 05 00 05 -> garbage ignored, no error; cmd_valid with code 05, arg 0, len 0.
- Bad checksum: AA 03 02 12 34 28 -> frame_err, err_code = 2; no cmd_valid; outputs keep the previous frame's values; frame_cnt unchanged.
- Bad length: AA 01 05 -> frame_err, err_code = 2'd1, pulsed on the LEN byte. A following good frame AA 01 01 FF FF decodes with arg 0x000000FF. (CHK = 01^01^FF = FF.)
- Timeout: AA 01 then no byte for TIMEOUT_CYCLES (use TIMEOUT_CYCLES = 100) -> frame_err with err_code = 3 exactly at the expiry cycle.
  - Repeat with a byte landing on the expiry cycle -> no error.
- Reset mid-frame: assert rst after AA 07 02 -> no pulses, busy = 0. Then a full frame decodes normally.
  - Also run 65536 good frames -> frame_cnt wraps to 0.
